// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit, the PC and the decoder.
package fetch_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    localparam logic [7:0] OP_RESTART = 8'h01;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PRESENT,
        S_STEP,
        S_SETTLE,
        S_HALT
    } state_e;

    function automatic logic is_busy(input state_e s);
        return !((s == S_IDLE) || (s == S_HALT));
    endfunction

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: one synchronous write port, one synchronous read-first read port.
module prog_mem #(
    parameter int unsigned ADDR_W = fetch_pkg::ADDR_W,
    parameter int unsigned DATA_W = fetch_pkg::DATA_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Both updates are non-blocking, so a same-address read returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads the word at pc_i, hands it to the decoder, then strobes e_o for the PC.
module instr_fetch #(
    parameter int unsigned         ADDR_W  = fetch_pkg::ADDR_W,
    parameter int unsigned         DATA_W  = fetch_pkg::DATA_W,
    parameter logic [DATA_W-1:0]   OP_HALT = DATA_W'(fetch_pkg::OP_HALT)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [DATA_W-1:0] di_o,
    output logic              di_valid_o,
    input  logic              di_ready_i,
    output logic              e_o,
    output logic              halted_o,
    output logic              busy_o
);

    import fetch_pkg::*;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic              di_valid_q, di_valid_d;
    logic              e_q, e_d;
    logic              halted_q, halted_d;
    logic              busy_q, busy_d;
    logic              rd_en_c;
    logic [DATA_W-1:0] rd_data;

    assign rd_en_c = (state_q == S_FETCH);

    prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prog_mem (
        .clk_i   (clk_i),
        .we_i    (ld_we_i),
        .waddr_i (ld_addr_i),
        .wdata_i (ld_data_i),
        .re_i    (rd_en_c),
        .raddr_i (pc_i),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // en_i only matters in IDLE and SETTLE, so a dropped enable lets the current instruction finish.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (en_i) state_d = S_FETCH;
            S_FETCH:   state_d = S_LATCH;
            S_LATCH:   state_d = S_PRESENT;
            S_PRESENT: if (di_ready_i) state_d = (di_q == OP_HALT) ? S_HALT : S_STEP;
            S_STEP:    state_d = S_SETTLE;
            S_SETTLE:  state_d = en_i ? S_FETCH : S_IDLE;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    // di_q is only rewritten in LATCH so it is still valid when the PC samples it on e_o.
    always_comb begin
        di_d       = di_q;
        di_valid_d = di_valid_q;
        e_d        = 1'b0;
        halted_d   = (state_d == S_HALT);
        busy_d     = is_busy(state_d);
        unique case (state_q)
            S_LATCH: begin
                di_d       = rd_data;
                di_valid_d = 1'b1;
            end
            S_PRESENT: begin
                if (di_ready_i) begin
                    di_valid_d = 1'b0;
                    e_d        = (di_q != OP_HALT);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            di_q       <= '0;
            di_valid_q <= 1'b0;
            e_q        <= 1'b0;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            di_q       <= di_d;
            di_valid_q <= di_valid_d;
            e_q        <= e_d;
            halted_q   <= halted_d;
            busy_q     <= busy_d;
        end
    end

    assign di_o       = di_q;
    assign di_valid_o = di_valid_q;
    assign e_o        = e_q;
    assign halted_o   = halted_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a behavioural PC driven by e_o.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       ready = 1'b0;
    logic       ld_we = 1'b0;
    logic [3:0] ld_addr = 4'd0;
    logic [7:0] ld_data = 8'd0;
    logic [3:0] pc = 4'd0;
    logic [7:0] di;
    logic       di_valid, e, halted, busy;

    int checks = 0;
    int failures = 0;
    int e_cnt = 0;
    logic       pc_force = 1'b0;
    logic [3:0] pc_force_val = 4'd0;

    typedef struct packed {
        logic       en;
        logic       rdy;
        logic [7:0] di;
        logic       v;
        logic       e;
        logic       busy;
    } vec_t;

    vec_t tv [23];

    instr_fetch dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .pc_i       (pc),
        .ld_we_i    (ld_we),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .di_o       (di),
        .di_valid_o (di_valid),
        .di_ready_i (ready),
        .e_o        (e),
        .halted_o   (halted),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // PC model: advances on the rising edge of e_o, restarts to 0 on opcode 8'h01.
    always @(posedge e or posedge pc_force) begin
        if (pc_force) begin
            pc = pc_force_val;
        end else begin
            e_cnt++;
            pc = (di == 8'h01) ? 4'd0 : pc + 4'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_pc(input logic [3:0] v);
        pc_force_val = v;
        pc_force = 1'b1;
        #1;
        pc_force = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_we = 1'b1;
        tick();
        ld_we = 1'b0;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0:       return di_valid;
            1:       return e;
            default: return halted;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int maxc, input string name);
        int n = 0;
        while (!probe(sel) && n < maxc) begin
            tick();
            n++;
        end
        if (!probe(sel)) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: still 0 after %0d cycles, required 1", name, maxc);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic ev, input logic b);
        vec_t r;
        r.en = 1'b1;
        r.rdy = 1'b1;
        r.di = d;
        r.v = v;
        r.e = ev;
        r.busy = b;
        return r;
    endfunction

    initial begin
        int e0;

        // Expected outputs after each clock edge, free-running from IDLE with pc=0.
        tv[0]  = mk(8'h00, 0, 0, 1);  tv[1]  = mk(8'h00, 0, 0, 1);
        tv[2]  = mk(8'h10, 1, 0, 1);  tv[3]  = mk(8'h10, 0, 1, 1);
        tv[4]  = mk(8'h10, 0, 0, 1);  tv[5]  = mk(8'h10, 0, 0, 1);
        tv[6]  = mk(8'h10, 0, 0, 1);  tv[7]  = mk(8'h20, 1, 0, 1);
        tv[8]  = mk(8'h20, 0, 1, 1);  tv[9]  = mk(8'h20, 0, 0, 1);
        tv[10] = mk(8'h20, 0, 0, 1);  tv[11] = mk(8'h20, 0, 0, 1);
        tv[12] = mk(8'h30, 1, 0, 1);  tv[13] = mk(8'h30, 0, 1, 1);
        tv[14] = mk(8'h30, 0, 0, 1);  tv[15] = mk(8'h30, 0, 0, 1);
        tv[16] = mk(8'h30, 0, 0, 1);  tv[17] = mk(8'h01, 1, 0, 1);
        tv[18] = mk(8'h01, 0, 1, 1);  tv[19] = mk(8'h01, 0, 0, 1);
        tv[20] = mk(8'h01, 0, 0, 1);  tv[21] = mk(8'h01, 0, 0, 1);
        tv[22] = mk(8'h10, 1, 0, 1);

        // Reset state
        tick();
        chk("rst_di", 32'(di), 32'h0);
        chk("rst_valid", 32'(di_valid), 32'h0);
        chk("rst_e", 32'(e), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        load(4'd0, 8'h10);
        load(4'd1, 8'h20);
        load(4'd2, 8'h30);
        load(4'd3, 8'h01);
        chk("idle_busy", 32'(busy), 32'h0);
        set_pc(4'd0);

        // Sequence 10,20,30, then restart via 01 back to mem[0]
        for (int i = 0; i < 23; i++) begin
            en = tv[i].en;
            ready = tv[i].rdy;
            tick();
            chk($sformatf("trace%0d", i), 32'({di, di_valid, e, busy}),
                32'({tv[i].di, tv[i].v, tv[i].e, tv[i].busy}));
        end
        en = 1'b0;
        tick(); tick(); tick(); tick();
        chk("drain_busy", 32'(busy), 32'h0);

        // Back-pressure at pc=1
        ready = 1'b0;
        en = 1'b1;
        wait_for(0, 10, "bp_valid");
        en = 1'b0;
        chk("bp_di", 32'(di), 32'h20);
        e0 = e_cnt;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("bp_hold%0d", k), 32'({di, di_valid, e}), 32'({8'h20, 1'b1, 1'b0}));
        end
        ready = 1'b1;
        tick();
        chk("bp_e_pulse", 32'({di, e}), 32'({8'h20, 1'b1}));
        tick();
        chk("bp_e_low", 32'(e), 32'h0);
        tick(); tick(); tick();
        chk("bp_e_count", 32'(e_cnt - e0), 32'd1);
        chk("bp_idle", 32'(busy), 32'h0);

        // Load collision: write mem[pc] during the FETCH cycle
        set_pc(4'd0);
        en = 1'b1;
        tick();
        chk("col_fetch_busy", 32'(busy), 32'h1);
        ld_addr = pc;
        ld_data = 8'hAA;
        ld_we = 1'b1;
        en = 1'b0;
        tick();
        ld_we = 1'b0;
        tick();
        chk("col_old_word", 32'({di, di_valid}), 32'({8'h10, 1'b1}));
        tick(); tick(); tick(); tick();
        set_pc(4'd0);
        en = 1'b1;
        wait_for(0, 10, "col_valid2");
        chk("col_new_word", 32'(di), 32'hAA);
        en = 1'b0;
        tick(); tick(); tick(); tick();

        // Reset while in STEP with e_o high
        set_pc(4'd2);
        en = 1'b1;
        ready = 1'b1;
        wait_for(1, 12, "rst_wait_e");
        chk("rst_pre_di", 32'(di), 32'h30);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_outs", 32'({di, di_valid, e, busy, halted}), 32'h0);
        tick();
        rst_n = 1'b1;
        wait_for(0, 10, "arst_restart");
        chk("arst_mem3", 32'(di), 32'h01);
        tick();
        chk("arst_restart_e", 32'({di, e}), 32'({8'h01, 1'b1}));
        en = 1'b0;
        tick(); tick(); tick();
        en = 1'b1;
        wait_for(0, 10, "arst_valid0");
        chk("arst_mem0", 32'(di), 32'hAA);
        en = 1'b0;
        tick(); tick(); tick(); tick();

        // Halt
        load(4'd1, 8'hFF);
        set_pc(4'd1);
        e0 = e_cnt;
        en = 1'b1;
        ready = 1'b1;
        wait_for(2, 15, "halt_wait");
        chk("halt_state", 32'({di, di_valid, halted, busy}), 32'({8'hFF, 1'b0, 1'b1, 1'b0}));
        for (int k = 0; k < 10; k++) begin
            en = k[0];
            tick();
            chk($sformatf("halt_hold%0d", k), 32'({halted, busy, e}), 32'({1'b1, 1'b0, 1'b0}));
        end
        chk("halt_no_e", 32'(e_cnt - e0), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("halt_rst", 32'({halted, busy}), 32'h0);
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        chk("halt_refetch", 32'(busy), 32'h1);
        en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
